// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// character-length encoding and the 2-of-3 vote used by the bit sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam logic [1:0] BITS_5 = 2'b00;
  localparam logic [1:0] BITS_6 = 2'b01;
  localparam logic [1:0] BITS_7 = 2'b10;
  localparam logic [1:0] BITS_8 = 2'b11;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  // Character length encoded as in LCR[1:0]: 00 -> 5 bits ... 11 -> 8 bits.
  function automatic logic [3:0] data_bits(input logic [1:0] cfg_bits);
    return MIN_DATA_BITS + {2'b00, cfg_bits};
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: metastability synchronizer on the pad, falling
// edge detect for start-bit hunting, and a 2-of-3 vote over the last three samples.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic rx_i,
  output logic fall,
  output logic vote
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             hist_q;
  logic                   cur;

  // NOTE: the line idles high, so these flops reset to 1; resetting them to 0
  // would manufacture a falling edge (a false start bit) right after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '1;
      hist_q <= '1;
    end else begin
      // NOTE: non-blocking assignments make every stage see its neighbour's
      // old value, which is what turns this into a shift chain.
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
    end
  end

  assign cur = sync_q[SYNC_STAGES-1];

  // At bit-timer half+1, hist_q holds the samples from half-1 and half.
  assign fall = hist_q[0] & ~cur;
  assign vote = majority3(hist_q[1], hist_q[0], cur);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: recovers start/data/parity/stop framing from the
// synchronized rx line and hands each character to the RX FIFO via valid/ready.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic [1:0]           cfg_bits_i,
  input  logic                 cfg_parity_en_i,
  input  logic                 cfg_even_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o,
  output logic                 rx_break_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam logic [DIV_WIDTH-1:0] TICK = DIV_WIDTH'(1);

  uart_rx_state_e       state_q, state_d;
  logic [DIV_WIDTH-1:0] timer_q, half;
  logic [3:0]           bit_cnt_q, n_bits;
  logic [7:0]           shreg_q, data_w;
  logic                 pbit_q;
  logic                 fall, vote, mid, last;
  logic                 shift_en, pbit_en, word_done;
  logic                 par_err_w, break_w;

  uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_sampler (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .rx_i   (rx_i),
    .fall   (fall),
    .vote   (vote)
  );

  assign half   = cfg_div_i >> 1;
  assign mid    = (timer_q == half + TICK);
  assign last   = (timer_q == cfg_div_i);
  assign n_bits = data_bits(cfg_bits_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so every path through the case assigns state_d
    // and no latch is inferred.
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (fall) state_d = START;
        START:   if (mid && vote) state_d = IDLE;
                 else if (last)   state_d = DATA;
        DATA:    if (last && bit_cnt_q == n_bits)
                   state_d = cfg_parity_en_i ? PARITY : STOP;
        PARITY:  if (last) state_d = STOP;
        STOP:    if (mid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en  = cfg_en_i && state_q == DATA   && mid;
    pbit_en   = cfg_en_i && state_q == PARITY && mid;
    word_done = cfg_en_i && state_q == STOP   && mid;
    busy_o    = (state_q != IDLE);
  end

  // The fall cycle counts as timer 0, so START begins at 1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      pbit_q    <= 1'b0;
    end else begin
      if (state_d == IDLE)      timer_q <= '0;
      else if (state_q == IDLE) timer_q <= TICK;
      else if (last)            timer_q <= '0;
      else                      timer_q <= timer_q + TICK;

      if (state_q != DATA) bit_cnt_q <= '0;
      else if (shift_en)   bit_cnt_q <= bit_cnt_q + 4'd1;

      if (shift_en) shreg_q <= {vote, shreg_q[7:1]};
      if (pbit_en)  pbit_q  <= vote;
    end
  end

  // Bits enter at the MSB, so short characters are right-aligned by 8-N.
  assign data_w    = shreg_q >> (4'd8 - n_bits);
  assign par_err_w = cfg_parity_en_i & (^{data_w, pbit_q} ^ ~cfg_even_i);
  assign break_w   = (data_w == 8'h00) & ~(cfg_parity_en_i & pbit_q) & ~vote;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_data_o       <= '0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_break_o      <= 1'b0;
      rx_valid_o      <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      overrun_o <= word_done & rx_valid_o & ~rx_ready_i;
      if (word_done && (!rx_valid_o || rx_ready_i)) begin
        rx_data_o       <= data_w;
        rx_parity_err_o <= par_err_w;
        rx_frame_err_o  <= ~vote;
        rx_break_o      <= break_w;
        rx_valid_o      <= 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule
